// File: rtl/rr_arbiter_8_pkg.sv
// rtl/rr_arbiter_8_pkg.sv - shared constants, state encoding and round-robin search for rr_arbiter_8
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set request found searching upward from ptr, wrapping 7 -> 0.
  // Only called when req is non-zero; with req == 0 the result is 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_dec.sv
// rtl/rr_arbiter_8_dec.sv - library 3-to-8 one-hot decoder
module rr_arbiter_8_dec
  import rr_arbiter_8_pkg::*;
(
  input  logic [ID_W-1:0]  sel,
  output logic [N_REQ-1:0] dec
);

  // One-hot decode of the select index.
  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-way round-robin arbiter with bounded grant hold
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = $clog2(MAX_HOLD) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [ID_W-1:0]   gnt_id_n;
  logic              gnt_valid_n;
  logic [N_REQ-1:0]  dec;

  // Next-state logic: pick a winner from IDLE, keep or release it in GRANT.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hold_cnt_n  = hold_cnt;
    gnt_id_n    = gnt_id;
    gnt_valid_n = gnt_valid;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_n     = ST_GRANT;
          gnt_id_n    = rr_pick(req, ptr);
          gnt_valid_n = 1'b1;
          hold_cnt_n  = '0;
        end
      end
      ST_GRANT: begin
        if (req[gnt_id] && (hold_cnt < HOLD_LAST)) begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end else begin
          // Voluntary or forced release; the winner drops to lowest priority.
          state_n     = ST_IDLE;
          gnt_valid_n = 1'b0;
          ptr_n       = gnt_id + ID_W'(1);
        end
      end
      default: begin
        state_n     = ST_IDLE;
        gnt_valid_n = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
    end
  end

  rr_arbiter_8_dec u_dec (
    .sel (gnt_id),
    .dec (dec)
  );

  // Grant vector is registers only: decoded index masked by the valid flag.
  always_comb begin
    gnt = dec & {N_REQ{gnt_valid}};
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;

  logic [7:0] gnt16, gnt4, gnt1;
  logic [2:0] id16, id4, id1;
  logic       val16, val4, val1;

  int n_total = 0;
  int n_pass  = 0;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt16), .gnt_id(id16), .gnt_valid(val16)
  );
  rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt4), .gnt_id(id4), .gnt_valid(val4)
  );
  rr_arbiter_8 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .gnt_id(id1), .gnt_valid(val1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       valid;
    logic [2:0] id;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_g;
    logic [7:0] seq1 [5];
    int         cnt;
    int         g;
    int         ph;

    rst = 1'b1;
    req = 8'h00;

    // rst, req, expected gnt, gnt_valid, gnt_id after the edge (MAX_HOLD=16 instance)
    vecs[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 8'hFF, 8'h01, 1'b1, 3'd0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 8'h05, 8'h04, 1'b1, 3'd2};
    vecs[5]  = '{1'b0, 8'h05, 8'h04, 1'b1, 3'd2};
    vecs[6]  = '{1'b0, 8'h01, 8'h00, 1'b0, 3'd2};
    vecs[7]  = '{1'b0, 8'h01, 8'h01, 1'b1, 3'd0};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 8'h80, 8'h80, 1'b1, 3'd7};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd7};
    vecs[11] = '{1'b0, 8'hC0, 8'h40, 1'b1, 3'd6};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd6};
    vecs[13] = '{1'b0, 8'h05, 8'h01, 1'b1, 3'd0};
    vecs[14] = '{1'b0, 8'h04, 8'h00, 1'b0, 3'd0};
    vecs[15] = '{1'b0, 8'h04, 8'h04, 1'b1, 3'd2};
    vecs[16] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd2};

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      step();
      check($sformatf("vec%0d_gnt", i),   32'(gnt16), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_valid", i), 32'(val16), 32'(vecs[i].valid));
      check($sformatf("vec%0d_id", i),    32'(id16),  32'(vecs[i].id));
    end

    // Voluntary release after three cycles, then re-grant of the same line.
    do_reset();
    req = 8'h08;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (gnt16 == 8'h08) cnt++;
    end
    check("vol_cycles", 32'(cnt), 32'd3);
    req = 8'h00;
    step();
    check("vol_release", 32'(gnt16), 32'h00);
    req = 8'h08;
    step();
    check("vol_regrant", 32'(gnt16), 32'h08);

    // Sole requester under MAX_HOLD=16: 16 on, 1 off, repeating.
    do_reset();
    req = 8'h20;
    for (int e = 1; e <= 34; e++) begin
      step();
      exp_g = ((e % 17) != 0) ? 8'h20 : 8'h00;
      check($sformatf("forced_e%0d", e), 32'(gnt16), 32'(exp_g));
    end

    // Full rotation under MAX_HOLD=4: 4 on, 1 off, order 0..7,0.
    do_reset();
    req = 8'hFF;
    for (int e = 1; e <= 45; e++) begin
      step();
      g  = ((e - 1) / 5) % 8;
      ph = (e - 1) % 5;
      exp_g = (ph < 4) ? (8'h01 << g) : 8'h00;
      check($sformatf("rot_e%0d_gnt", e), 32'(gnt4), 32'(exp_g));
      if (ph < 4) check($sformatf("rot_e%0d_id", e), 32'(id4), 32'(g));
    end

    // MAX_HOLD=1: single-cycle grants with bubbles, rotating 0,1,0.
    do_reset();
    req = 8'h03;
    seq1[0] = 8'h01; seq1[1] = 8'h00; seq1[2] = 8'h02; seq1[3] = 8'h00; seq1[4] = 8'h01;
    for (int e = 0; e < 5; e++) begin
      step();
      check($sformatf("hold1_e%0d", e), 32'(gnt1), 32'(seq1[e]));
    end

    // Reset in the middle of a grant to requester 3.
    do_reset();
    req = 8'h08;
    step();
    for (int i = 0; i < 5; i++) step();
    check("mid_pre_id", 32'(id16), 32'd3);
    rst = 1'b1;
    step();
    check("mid_rst_gnt",   32'(gnt16), 32'h00);
    check("mid_rst_valid", 32'(val16), 32'd0);
    check("mid_rst_id",    32'(id16),  32'd0);
    rst = 1'b0;
    req = 8'h0A;
    step();
    check("mid_after_id",  32'(id16),  32'd1);
    check("mid_after_gnt", 32'(gnt16), 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
